// File: rtl/mux_rr_arbiter.sv
// Eight-requester round-robin arbiter. It drives the select of a shared
// 8:1 data mux and caps how long one owner holds the grant while others wait.
module mux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] A,
    output logic [2:0] Sel,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       gnt_start,
    output logic       F
);

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned HOLD_W  = 4;
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 start_q, start_d;
    logic                 f_q, f_d;

    logic                 found_c;
    logic [IDX_W-1:0]     winner_c;
    logic [IDX_W-1:0]     idx_c;
    logic                 others_c;

    // Round-robin search starting just after the last owner; last owner is checked last.
    always_comb begin
        found_c  = 1'b0;
        winner_c = last_q;
        idx_c    = last_q;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            idx_c = last_q + IDX_W'(k);
            if (!found_c && req[idx_c]) begin
                found_c  = 1'b1;
                winner_c = idx_c;
            end
        end
    end

    // Someone other than the current owner is asking.
    assign others_c = |(req & ~gnt_q);

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        hold_d  = hold_q;
        start_d = 1'b0;
        f_d     = (state_q == GRANT) ? A[sel_q] : 1'b0;

        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (found_c) begin
                    state_d = GRANT;
                    sel_d   = winner_c;
                    gnt_d   = NUM_REQ'(1) << winner_c;
                    last_d  = winner_c;
                    hold_d  = '0;
                    start_d = 1'b1;
                end
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    // Release only; arbitration resumes from IDLE next cycle.
                    state_d = IDLE;
                    gnt_d   = '0;
                    hold_d  = '0;
                end else if (hold_q >= HOLD_LIMIT) begin
                    if (others_c) begin
                        sel_d   = winner_c;
                        gnt_d   = NUM_REQ'(1) << winner_c;
                        last_d  = winner_c;
                        hold_d  = '0;
                        start_d = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            hold_q  <= '0;
            start_q <= 1'b0;
            f_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            start_q <= start_d;
            f_q     <= f_d;
        end
    end

    assign Sel       = sel_q;
    assign gnt       = gnt_q;
    assign busy      = (state_q == GRANT);
    assign gnt_start = start_q;
    assign F         = f_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: directed scenarios followed by random traffic.
module tb_mux_rr_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] A;
    logic [2:0] Sel;
    logic [7:0] gnt;
    logic       busy;
    logic       gnt_start;
    logic       F;

    mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .A         (A),
        .Sel       (Sel),
        .gnt       (gnt),
        .busy      (busy),
        .gnt_start (gnt_start),
        .F         (F)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] gnt;
        logic       busy;
        logic       start;
        logic       f;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference model: owner as an integer (-1 = nobody), plain modulo search.
    int m_owner = -1;
    int m_last  = 7;
    int m_sel   = 0;
    int m_held  = 0;   // grant cycles completed by the owner minus one

    function automatic int rr_pick(input logic [7:0] r, input int from);
        for (int k = 1; k <= 8; k++) begin
            if (r[(from + k) % 8]) return (from + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r_st, input logic [7:0] r, input logic [7:0] a);
        exp_t e;
        int   w;
        logic f_new;
        logic start;
        start = 1'b0;
        if (r_st) begin
            m_owner = -1; m_last = 7; m_sel = 0; m_held = 0;
            f_new = 1'b0;
        end else begin
            f_new = (m_owner >= 0) ? a[m_sel] : 1'b0;
            if (m_owner < 0) begin
                w = rr_pick(r, m_last);
                if (w >= 0) begin
                    m_owner = w; m_sel = w; m_last = w; m_held = 0; start = 1'b1;
                end
            end else if (!r[m_owner]) begin
                m_owner = -1; m_held = 0;
            end else if (m_held + 1 < MAX_HOLD) begin
                m_held++;
            end else if ((r & ~(8'h01 << m_owner)) != 8'h00) begin
                w = rr_pick(r, m_last);
                m_owner = w; m_sel = w; m_last = w; m_held = 0; start = 1'b1;
            end
        end
        e.sel   = 3'(m_sel);
        e.gnt   = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        e.busy  = (m_owner >= 0);
        e.start = start;
        e.f     = f_new;
        exp_q.push_back(e);
    endtask

    // Apply one cycle of inputs, record the expected post-edge outputs.
    task automatic drive(input logic r_st, input logic [7:0] r, input logic [7:0] a);
        rst = r_st;
        req = r;
        A   = a;
        model_step(r_st, r, a);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL cycle %0d %s: got %0h expected %0h", cyc, nm, act, expv);
        end
    endtask

    // Monitor: every edge the DUT presents new outputs, compare to the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("Sel",       int'(Sel),       int'(e.sel));
                chk("gnt",       int'(gnt),       int'(e.gnt));
                chk("busy",      int'(busy),      int'(e.busy));
                chk("gnt_start", int'(gnt_start), int'(e.start));
                chk("F",         int'(F),         int'(e.f));
                n_tests++;
                if (gnt != 8'h00 && (gnt & (gnt - 8'h01)) != 8'h00) begin
                    n_fail++;
                    $display("FAIL cycle %0d onehot: gnt=%0h", cyc, gnt);
                end
            end
        end
    end

    initial begin
        logic [7:0] r;
        int         sel_r;

        // Reset, then a single requester with its data bit high.
        drive(1'b1, 8'h00, 8'h00);
        drive(1'b1, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) drive(1'b0, 8'h01, 8'h01);
        drive(1'b0, 8'h00, 8'h00);

        // Everyone requesting: full rotation, 4 cycles each, random data.
        for (int i = 0; i < 40; i++) drive(1'b0, 8'hFF, 8'($urandom));
        drive(1'b0, 8'h00, 8'h00);

        // Owner 3 drops while 5 waits: one idle cycle, then 5.
        drive(1'b0, 8'h08, 8'hFF);
        drive(1'b0, 8'h28, 8'h08);
        drive(1'b0, 8'h28, 8'h00);
        drive(1'b0, 8'h20, 8'h20);
        drive(1'b0, 8'h20, 8'h20);
        drive(1'b0, 8'h20, 8'h00);
        drive(1'b0, 8'h00, 8'h00);

        // Lone requester 6 keeps the grant past the hold limit.
        for (int i = 0; i < 10; i++) drive(1'b0, 8'h40, 8'($urandom));
        drive(1'b0, 8'h00, 8'h00);

        // Reset mid-grant to requester 2, then 2 and 7 compete.
        drive(1'b0, 8'h04, 8'h04);
        drive(1'b0, 8'h04, 8'h04);
        drive(1'b1, 8'h04, 8'h04);
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h84, 8'h84);
        drive(1'b0, 8'h00, 8'h00);

        // Wrap-around fairness: 0 wins after reset, 7 wins next time.
        drive(1'b1, 8'h00, 8'h00);
        drive(1'b0, 8'h81, 8'h81);
        drive(1'b0, 8'h81, 8'h00);
        drive(1'b0, 8'h80, 8'h80);
        drive(1'b0, 8'h00, 8'h00);
        drive(1'b0, 8'h81, 8'h81);
        drive(1'b0, 8'h81, 8'h81);
        drive(1'b0, 8'h00, 8'h00);

        // Random traffic with occasional resets.
        r = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            sel_r = int'($urandom_range(0, 9));
            if (sel_r < 5)      r = r;
            else if (sel_r < 7) r = 8'($urandom_range(0, 255));
            else if (sel_r < 8) r = 8'h00;
            else                r = r ^ (8'h01 << $urandom_range(0, 7));
            drive(($urandom_range(0, 99) == 0), r, 8'($urandom));
        end
        drive(1'b0, 8'h00, 8'h00);

        // Let the monitor drain the final expectation.
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
